// File: rtl/knn_pkg.sv
// Shared definitions for the KNN pipeline stages: FSM encoding and sizing helpers.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2
  } knn_state_t;

  // Vote counters must hold the value K without wrapping.
  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

  // Slot index width; at least one bit so K=1 still has a legal vector.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/knn_vote.sv
// Majority vote over the K nearest of N sorted neighbours.
// Tally phase walks K slots incrementing a per-label counter bank; select phase
// walks them again and keeps the first label with the strictly highest count,
// so ties go to the nearest slot.
module knn_vote
  import knn_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int TYPE_W = 4,
  parameter int K      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_sort,
  input  logic [N*W-1:0]        distance_array_sorted,
  input  logic [N*TYPE_W-1:0]   type_array_sorted,
  output logic [TYPE_W-1:0]     class_type,
  output logic [W-1:0]          nearest_distance,
  output logic                  class_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NUM_LBL = 1 << TYPE_W;
  localparam int CNT_W   = cnt_width(K);
  localparam int IDX_W   = idx_width(K);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(K);

  generate
    if (K < 1 || K > N) begin : g_bad_k
      $error("knn_vote: K must lie in 1..N");
    end
  endgenerate

  // Only slot-0 distance and the first K labels matter; the rest is dropped.
  logic unused_dist;
  logic unused_typ;
  generate
    if (N > 1) begin : g_ud
      assign unused_dist = ^distance_array_sorted[N*W-1:W];
    end else begin : g_ud0
      assign unused_dist = 1'b0;
    end
    if (K < N) begin : g_ut
      assign unused_typ = ^type_array_sorted[N*TYPE_W-1:K*TYPE_W];
    end else begin : g_ut0
      assign unused_typ = 1'b0;
    end
  endgenerate

  knn_state_t                 state;
  logic [K-1:0][TYPE_W-1:0]   typ_q;
  logic [W-1:0]               dist_q;
  logic [CNT_W-1:0]           cnt [NUM_LBL];
  logic [IDX_W-1:0]           idx;
  logic [TYPE_W-1:0]          best_lbl;
  logic [CNT_W-1:0]           best_cnt;

  logic [TYPE_W-1:0]          cur_typ;
  logic [CNT_W-1:0]           cur_cnt;
  logic                       take;
  logic [TYPE_W-1:0]          nxt_lbl;
  logic [CNT_W-1:0]           nxt_cnt;

  // Candidate for the current slot; slot 0 always seeds the running best.
  always_comb begin
    cur_typ = typ_q[idx];
    cur_cnt = cnt[cur_typ];
    take    = (idx == '0) || (cur_cnt > best_cnt);
    nxt_lbl = take ? cur_typ : best_lbl;
    nxt_cnt = take ? cur_cnt : best_cnt;
  end

  // Control FSM, counter bank and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      typ_q            <= '0;
      dist_q           <= '0;
      idx              <= '0;
      best_lbl         <= '0;
      best_cnt         <= '0;
      class_type       <= '0;
      nearest_distance <= '0;
      class_valid      <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      for (int i = 0; i < NUM_LBL; i++) cnt[i] <= '0;
    end else begin
      class_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_sort) begin
            for (int i = 0; i < K; i++)
              typ_q[i] <= type_array_sorted[i*TYPE_W +: TYPE_W];
            dist_q <= distance_array_sorted[W-1:0];
            for (int i = 0; i < NUM_LBL; i++) cnt[i] <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          // Saturate rather than wrap; K votes always fit, this is a guard.
          if (cur_cnt != CNT_MAX) cnt[cur_typ] <= cur_cnt + CNT_W'(1);
          if (idx == LAST) begin
            idx   <= '0;
            state <= SELECT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        SELECT: begin
          best_lbl <= nxt_lbl;
          best_cnt <= nxt_cnt;
          if (idx == LAST) begin
            idx              <= '0;
            class_type       <= nxt_lbl;
            nearest_distance <= dist_q;
            class_valid      <= 1'b1;
            busy             <= 1'b0;
            state            <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // A request arriving mid-flight is dropped and remembered.
      if (valid_sort && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Randomised scoreboard bench for knn_vote (N=4, K=3, TYPE_W=4, W=8).
module tb_knn_vote;

  localparam int N = 4, W = 8, TYPE_W = 4, K = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_sort;
  logic [N*W-1:0]      dist_in;
  logic [N*TYPE_W-1:0] type_in;
  logic [TYPE_W-1:0]   class_type;
  logic [W-1:0]        nearest_distance;
  logic                class_valid;
  logic                busy;
  logic                overrun;

  knn_vote #(.N(N), .W(W), .TYPE_W(TYPE_W), .K(K)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid_sort            (valid_sort),
    .distance_array_sorted (dist_in),
    .type_array_sorted     (type_in),
    .class_type            (class_type),
    .nearest_distance      (nearest_distance),
    .class_valid           (class_valid),
    .busy                  (busy),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TYPE_W-1:0] ct;
    logic [W-1:0]      nd;
    int                cap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   next_free = 0;
  logic ovr_model = 1'b0;
  logic [TYPE_W-1:0] last_ct;
  logic [W-1:0]      last_nd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [N*TYPE_W-1:0] pk(input int a, input int b, input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  function automatic logic [N*W-1:0] pkd(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reference: most frequent label among the first K slots; among equally
  // frequent labels, the one appearing at the lowest slot.
  function automatic logic [TYPE_W-1:0] ref_class(input logic [N*TYPE_W-1:0] tv);
    int votes [1<<TYPE_W];
    int best;
    foreach (votes[i]) votes[i] = 0;
    for (int s = 0; s < K; s++) votes[tv[s*TYPE_W +: TYPE_W]]++;
    best = 0;
    foreach (votes[i]) if (votes[i] > best) best = votes[i];
    for (int s = 0; s < K; s++)
      if (votes[tv[s*TYPE_W +: TYPE_W]] == best) return tv[s*TYPE_W +: TYPE_W];
    return '0;
  endfunction

  // Called #1 after an edge; request is captured at the next edge.
  task automatic send(input logic [N*TYPE_W-1:0] tv, input logic [N*W-1:0] dv);
    exp_t e;
    int cap;
    cap = cyc + 1;
    type_in    = tv;
    dist_in    = dv;
    valid_sort = 1'b1;
    if (cap >= next_free) begin
      e.ct = ref_class(tv);
      e.nd = dv[W-1:0];
      e.cap = cap;
      sb.push_back(e);
      next_free = cap + 2*K + 1;
    end else begin
      ovr_model = 1'b1;
    end
    @(posedge clk); #1;
    valid_sort = 1'b0;
    type_in = N*TYPE_W'($urandom);
    dist_in = N*W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every class_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && class_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", class_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("class_type", class_type, e.ct);
        chk("nearest_distance", nearest_distance, e.nd);
        chk("latency", cyc - e.cap, 2*K);
        last_ct = e.ct;
        last_nd = e.nd;
      end
    end
  end

  initial begin
    logic [N*TYPE_W-1:0] tv;
    rst = 1'b1; valid_sort = 1'b0; dist_in = '0; type_in = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_class_type", class_type, 0);
    chk("rst_nearest", nearest_distance, 0);
    chk("rst_valid", class_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Majority
    send(pk(2,5,2,7), pkd(3,9,12,40));
    chk("busy_in_flight", busy, 1);
    drain();
    chk("hold_type", class_type, last_ct);
    chk("hold_dist", nearest_distance, last_nd);

    // Tie, nearest wins
    send(pk(5,2,7,5), pkd(1,2,3,4));
    drain();

    // Input stability: inputs change right after capture
    send(pk(2,5,2,7), pkd(17,20,30,31));
    type_in = pk(9,9,9,9);
    drain();

    // Back-to-back on the class_valid cycle
    send(pk(1,2,3,1), pkd(5,6,7,8));
    repeat (2*K) @(posedge clk); #1;
    chk("b2b_valid_now", class_valid, 1);
    chk("b2b_idle_now", busy, 0);
    send(pk(4,4,4,4), pkd(11,12,13,14));
    drain();
    chk("b2b_no_overrun", overrun, ovr_model);

    // Overrun: second request two cycles after the first
    send(pk(3,3,6,1), pkd(50,60,70,80));
    @(posedge clk); #1;
    send(pk(8,8,8,8), pkd(99,99,99,99));
    drain();
    chk("overrun_set", overrun, ovr_model);
    repeat (10) @(posedge clk); #1;
    chk("overrun_held", overrun, ovr_model);

    // Reset mid-COUNT
    send(pk(6,6,6,6), pkd(21,22,23,24));
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_type", class_type, 0);
    chk("mid_rst_dist", nearest_distance, 0);
    chk("mid_rst_valid", class_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    sb.delete();
    ovr_model = 1'b0;
    next_free = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(pk(1,1,3,0), pkd(2,4,6,8));
    drain();
    chk("post_rst_overrun", overrun, ovr_model);

    // Randomised traffic, including early requests that must be dropped
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 9)) @(posedge clk);
      #1;
      if (i % 2 == 0) tv = pk($urandom_range(0,2), $urandom_range(0,2), $urandom_range(0,2), $urandom_range(0,2));
      else            tv = N*TYPE_W'($urandom);
      send(tv, N*W'($urandom));
    end
    drain();
    chk("rand_overrun", overrun, ovr_model);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/knn_vote.md
KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N, 4: sorted entries per request.
- W, 8: distance width.
- TYPE_W, 4: class label width.
- K, 3: neighbours voted, legal range 1..N.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- valid_sort, in, 1: one-cycle pulse; sorted arrays are valid.
- distance_array_sorted, in, N*W: slot i at [i*W +: W]; slot 0 is the nearest.
- type_array_sorted, in, N*TYPE_W: label of slot i at [i*TYPE_W +: TYPE_W].
- class_type, out, TYPE_W: winning label.
- nearest_distance, out, W: distance of slot 0 for the classified request.
- class_valid, out, 1: one-cycle pulse; class_type and nearest_distance are valid.
- busy, out, 1: high while a request is in progress.
- overrun, out, 1: sticky flag; a request was dropped.

REQ-003 A parameter set with K=0 or K>N SHALL be rejected at elaboration.

Function
REQ-004 The FSM SHALL have three states: IDLE, COUNT, SELECT.
REQ-005 In IDLE, valid_sort=1 SHALL cause these actions at that edge:
- capture the first K type slots and slot-0 distance into local registers;
- clear all 2^TYPE_W vote counters;
- clear the slot index;
- move to COUNT.
REQ-006 COUNT SHALL process one slot per cycle, slot index 0..K-1, incrementing counter[type[slot]]; after slot K-1 it SHALL move to SELECT with the index cleared.
REQ-007 Vote counters SHALL be $clog2(K+1) bits wide and SHALL never wrap.
REQ-008 SELECT SHALL scan slots 0..K-1, one per cycle. The best candidate SHALL update only when counter[type[slot]] > best_count (strictly greater), so ties resolve to the label whose nearest occurrence has the lowest slot index.
REQ-009 best_count and the best label SHALL be loaded from slot 0 on the first SELECT cycle.
REQ-010 After the last SELECT slot, the FSM SHALL return to IDLE with these register updates:
- class_type = best label;
- nearest_distance = captured slot-0 distance;
- class_valid = 1 for exactly one cycle.
REQ-011 Latency SHALL be exactly 2K clock edges from the capturing edge to the edge that raises class_valid; with K=3 this is 6.
REQ-012 busy SHALL be 1 in COUNT and SELECT and 0 in IDLE.
REQ-013 valid_sort SHALL be accepted in the IDLE cycle in which class_valid=1, so back-to-back requests run with no gap.
REQ-014 valid_sort asserted while busy=1 SHALL be ignored; the in-flight request SHALL complete unaffected, and overrun SHALL be set and held until reset.
REQ-015 Input arrays SHALL be sampled only at the capture edge; later input changes SHALL have no effect on the in-flight request.
REQ-016 class_type and nearest_distance SHALL hold their values between class_valid pulses.

Reset
REQ-017 rst=1 SHALL asynchronously force these values, from any state including mid-COUNT/SELECT, discarding the in-flight request:
- state = IDLE;
- class_type = 0;
- nearest_distance = 0;
- class_valid = 0;
- busy = 0;
- overrun = 0;
- all counters = 0.
REQ-018 The first valid_sort after reset release SHALL be processed normally.

Structure
REQ-019 The FSM state encoding and the counter-width function SHALL live in a shared package knn_pkg, reused by the KNN stages.
REQ-020 The block SHALL be a single module with no sub-modules; the counter bank is a register array indexed by label.

Verification
(All scenarios use N=4, K=3, TYPE_W=4.)
REQ-021 Majority: types {2,5,2,7}, distances {3,9,12,40}, valid_sort pulse -> 6 edges later class_valid=1, class_type=2, nearest_distance=3.
REQ-022 Tie, nearest wins: types {5,2,7,5} -> class_type=5 (slot 3 lies outside K, so all counts are 1 and slot 0 wins).
REQ-023 Overrun: a second valid_sort 2 cycles after the first -> the first result is delivered unchanged, no second class_valid, overrun=1 held.
REQ-024 Reset mid-COUNT: rst asserted 2 cycles after capture -> all outputs 0 immediately, no class_valid; a subsequent request with types {1,1,3,0} yields class_type=1 after 6 edges.
REQ-025 Back-to-back: second valid_sort coincident with the first class_valid pulse, types {4,4,4,4} -> second class_valid 6 edges later, class_type=4, overrun=0.
REQ-026 Input stability: inputs changed to {9,9,9,9} the cycle after capture of {2,5,2,7} -> class_type=2.
